// File: rtl/nx_mesh_loader.sv
// Host-side loader: turns a (row, col, count) request plus an instruction stream
// into LOAD_INSTR mesh messages over a single-register valid/ready output stage.
module nx_mesh_loader #(
    parameter  int unsigned STREAM_WIDTH   = 32,
    parameter  int unsigned ADDR_ROW_WIDTH = 4,
    parameter  int unsigned ADDR_COL_WIDTH = 4,
    parameter  int unsigned COMMAND_WIDTH  = 2,
    parameter  int unsigned INSTR_WIDTH    = 15,
    parameter  int unsigned MAX_INSTRS     = 512,
    parameter  int unsigned CMD_LOAD_INSTR = 0,
    localparam int unsigned COUNT_WIDTH    = $clog2(MAX_INSTRS + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [ADDR_ROW_WIDTH-1:0] req_row_i,
    input  logic [ADDR_COL_WIDTH-1:0] req_col_i,
    input  logic [COUNT_WIDTH-1:0]    req_count_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [INSTR_WIDTH-1:0]    instr_data_i,
    input  logic                      instr_valid_i,
    output logic                      instr_ready_o,
    output logic [STREAM_WIDTH-1:0]   mesh_data_o,
    output logic                      mesh_valid_o,
    input  logic                      mesh_ready_i,
    output logic                      busy_o,
    output logic                      loaded_o,
    output logic [COUNT_WIDTH-1:0]    sent_count_o
);

    localparam int unsigned PAYLOAD_WIDTH =
        STREAM_WIDTH - ADDR_ROW_WIDTH - ADDR_COL_WIDTH - COMMAND_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e                    state_q;
    logic [ADDR_ROW_WIDTH-1:0] row_q;
    logic [ADDR_COL_WIDTH-1:0] col_q;
    logic [COUNT_WIDTH-1:0]    remaining_q;
    logic [COUNT_WIDTH-1:0]    sent_count_q;
    logic [STREAM_WIDTH-1:0]   mesh_data_q;
    logic                      mesh_valid_q;

    logic [COUNT_WIDTH-1:0]    req_count_d;
    logic [STREAM_WIDTH-1:0]   mesh_data_d;
    logic                      mesh_valid_d;
    logic                      instr_hs;
    logic                      mesh_hs;

    // Ready decodes come straight off the state register; instr_ready also
    // looks through the output register so a draining word frees the slot.
    assign req_ready_o   = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign loaded_o      = (state_q == DONE);
    assign instr_ready_o = (state_q == STREAM) && (!mesh_valid_q || mesh_ready_i);

    assign instr_hs = instr_valid_i && instr_ready_o;
    assign mesh_hs  = mesh_valid_q && mesh_ready_i;

    assign req_count_d = (req_count_i > COUNT_WIDTH'(MAX_INSTRS))
                       ? COUNT_WIDTH'(MAX_INSTRS) : req_count_i;

    // Output stage: a new word replaces the old one in the same cycle it drains.
    always_comb begin
        mesh_data_d  = mesh_data_q;
        mesh_valid_d = mesh_valid_q;
        if (instr_hs) begin
            mesh_data_d  = {row_q, col_q, COMMAND_WIDTH'(CMD_LOAD_INSTR),
                            PAYLOAD_WIDTH'(instr_data_i)};
            mesh_valid_d = 1'b1;
        end else if (mesh_hs) begin
            mesh_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            remaining_q  <= '0;
            sent_count_q <= '0;
            mesh_data_q  <= '0;
            mesh_valid_q <= 1'b0;
        end else begin
            mesh_data_q  <= mesh_data_d;
            mesh_valid_q <= mesh_valid_d;
            if (mesh_hs) begin
                sent_count_q <= sent_count_q + COUNT_WIDTH'(1);
            end
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        row_q        <= req_row_i;
                        col_q        <= req_col_i;
                        remaining_q  <= req_count_d;
                        sent_count_q <= '0;
                        state_q      <= (req_count_d != '0) ? STREAM : DONE;
                    end
                end
                STREAM: begin
                    if (instr_hs) begin
                        remaining_q <= remaining_q - COUNT_WIDTH'(1);
                        if (remaining_q == COUNT_WIDTH'(1)) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (mesh_hs || !mesh_valid_q) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mesh_data_o  = mesh_data_q;
    assign mesh_valid_o = mesh_valid_q;
    assign sent_count_o = sent_count_q;

endmodule
